// File: rtl/i2c_cmd_sequencer.sv
// Command FIFO and transaction sequencer in front of the I2C master.
// Issues one master transaction per queued command and returns one in-order response each.
module i2c_cmd_sequencer #(
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 65535
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_cmd_valid,
  output logic                     o_cmd_ready,
  input  logic                     i_cmd_rw,
  input  logic [ADDR_W-1:0]        i_cmd_addr,
  input  logic [DATA_W-1:0]        i_cmd_wdata,
  output logic                     o_rsp_valid,
  input  logic                     i_rsp_ready,
  output logic [DATA_W-1:0]        o_rsp_rdata,
  output logic [1:0]               o_rsp_err,
  output logic                     o_start_txn,
  output logic                     o_rw,
  output logic [ADDR_W-1:0]        o_sub_addr,
  output logic [DATA_W-1:0]        o_master_data_in,
  input  logic                     i_master_busy,
  input  logic                     i_master_done,
  input  logic                     i_master_ack_error,
  input  logic [DATA_W-1:0]        i_master_data_out,
  output logic [$clog2(DEPTH):0]   o_cmd_count,
  output logic                     o_idle
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int EW = 1 + ADDR_W + DATA_W;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_NACK    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  // state  | meaning
  // IDLE   | waiting for a queued command
  // LAUNCH | start_txn asserted, waiting for master busy/done
  // RUN    | master busy, waiting for done
  // RESP   | result captured, waiting for the response slot
  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_RUN, S_RESP} state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [EW-1:0]     r_mem [DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic [TW-1:0]     r_tmo_cnt;
  logic              r_rw;
  logic [ADDR_W-1:0] r_sub_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_res_rdata;
  logic [1:0]        r_res_err;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic [1:0]        r_rsp_err;

  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_capture;
  logic              w_timeout;
  logic              w_rsp_load;
  logic              w_tc;
  logic [EW-1:0]     w_head;

  assign w_full   = (r_count == CW'(DEPTH));
  assign w_empty  = (r_count == '0);
  assign w_push   = i_cmd_valid && o_cmd_ready;
  assign w_head   = r_mem[r_rd_ptr];
  assign w_tc     = (r_tmo_cnt == TW'(TIMEOUT - 1));

  assign o_cmd_ready      = !w_full && !i_rst;
  assign o_cmd_count      = r_count;
  assign o_start_txn      = (r_state == S_LAUNCH);
  assign o_rw             = r_rw;
  assign o_sub_addr       = r_sub_addr;
  assign o_master_data_in = r_wdata;
  assign o_rsp_valid      = r_rsp_valid;
  assign o_rsp_rdata      = r_rsp_rdata;
  assign o_rsp_err        = r_rsp_err;
  assign o_idle           = (r_state == S_IDLE) && w_empty && !r_rsp_valid;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_capture   = 1'b0;
    w_timeout   = 1'b0;
    w_rsp_load  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_LAUNCH;
        end
      end
      S_LAUNCH, S_RUN: begin
        // done wins over both timeout and busy, even in LAUNCH
        if (i_master_done) begin
          w_capture   = 1'b1;
          w_state_nxt = S_RESP;
        end else if (w_tc) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_RESP;
        end else if ((r_state == S_LAUNCH) && i_master_busy) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RESP: begin
        if (!r_rsp_valid || i_rsp_ready) begin
          w_rsp_load  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {i_cmd_rw, i_cmd_addr, i_cmd_wdata};
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rw       <= 1'b0;
      r_sub_addr <= '0;
      r_wdata    <= '0;
      r_tmo_cnt  <= '0;
    end else begin
      if (w_pop) begin
        r_rw       <= w_head[EW-1];
        r_sub_addr <= w_head[DATA_W +: ADDR_W];
        r_wdata    <= w_head[DATA_W-1:0];
        r_tmo_cnt  <= '0;
      end else if ((r_state == S_LAUNCH) || (r_state == S_RUN)) begin
        r_tmo_cnt  <= r_tmo_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_res_rdata <= '0;
      r_res_err   <= ERR_OK;
    end else if (w_capture) begin
      r_res_rdata <= (r_rw && !i_master_ack_error) ? i_master_data_out : '0;
      r_res_err   <= i_master_ack_error ? ERR_NACK : ERR_OK;
    end else if (w_timeout) begin
      r_res_rdata <= '0;
      r_res_err   <= ERR_TIMEOUT;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= ERR_OK;
    end else if (w_rsp_load) begin
      r_rsp_valid <= 1'b1;
      r_rsp_rdata <= r_res_rdata;
      r_rsp_err   <= r_res_err;
    end else if (i_rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Directed bench for i2c_cmd_sequencer: main instance plus a short-timeout instance.
module tb_i2c_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready, cmd_rw;
  logic [6:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_rdata;
  logic [1:0] rsp_err;
  logic       start_txn, rw;
  logic [6:0] sub_addr;
  logic [7:0] mdi;
  logic       master_busy, master_done, master_ack_error;
  logic [7:0] master_data_out;
  logic [2:0] cmd_count;
  logic       idle;

  logic       t_cmd_valid, t_cmd_ready, t_rsp_valid, t_rsp_ready, t_start_txn, t_rw, t_idle;
  logic [7:0] t_rsp_rdata, t_mdi;
  logic [1:0] t_rsp_err;
  logic [6:0] t_sub_addr;
  logic [2:0] t_cmd_count;

  int n_tests = 0;
  int n_fail  = 0;

  logic       c_rw [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [6:0] c_ad [5] = '{7'h20, 7'h21, 7'h22, 7'h23, 7'h24};
  logic [7:0] c_rd [5] = '{8'hA0, 8'h00, 8'hA2, 8'h00, 8'hA4};

  always #5 clk = ~clk;

  i2c_cmd_sequencer #(.DEPTH(4), .ADDR_W(7), .DATA_W(8), .TIMEOUT(65535)) u_dut (
    .i_clk(clk), .i_rst(rst),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_rw(cmd_rw),
    .i_cmd_addr(cmd_addr), .i_cmd_wdata(cmd_wdata),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err),
    .o_start_txn(start_txn), .o_rw(rw), .o_sub_addr(sub_addr), .o_master_data_in(mdi),
    .i_master_busy(master_busy), .i_master_done(master_done),
    .i_master_ack_error(master_ack_error), .i_master_data_out(master_data_out),
    .o_cmd_count(cmd_count), .o_idle(idle)
  );

  i2c_cmd_sequencer #(.DEPTH(4), .ADDR_W(7), .DATA_W(8), .TIMEOUT(100)) u_dut_tmo (
    .i_clk(clk), .i_rst(rst),
    .i_cmd_valid(t_cmd_valid), .o_cmd_ready(t_cmd_ready), .i_cmd_rw(1'b1),
    .i_cmd_addr(7'h44), .i_cmd_wdata(8'h00),
    .o_rsp_valid(t_rsp_valid), .i_rsp_ready(t_rsp_ready), .o_rsp_rdata(t_rsp_rdata), .o_rsp_err(t_rsp_err),
    .o_start_txn(t_start_txn), .o_rw(t_rw), .o_sub_addr(t_sub_addr), .o_master_data_in(t_mdi),
    .i_master_busy(1'b0), .i_master_done(1'b0),
    .i_master_ack_error(1'b0), .i_master_data_out(8'h5A),
    .o_cmd_count(t_cmd_count), .o_idle(t_idle)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic r, input logic [6:0] a, input logic [7:0] d);
    cmd_valid = 1'b1; cmd_rw = r; cmd_addr = a; cmd_wdata = d;
    cyc();
    cmd_valid = 1'b0;
  endtask

  task automatic finish_txn(input logic ack, input logic [7:0] d);
    master_done = 1'b1; master_ack_error = ack; master_data_out = d; master_busy = 1'b0;
    cyc();
    master_done = 1'b0; master_ack_error = 1'b0; master_data_out = 8'hEE;
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    while (!start_txn && n < 50) begin cyc(); n++; end
    chk(tag, 32'(start_txn), 1);
  endtask

  task automatic get_rsp(input string tag, input logic [7:0] exp_rd, input logic [1:0] exp_err);
    int n = 0;
    while (!rsp_valid && n < 50) begin cyc(); n++; end
    chk({tag, "_valid"}, 32'(rsp_valid), 1);
    chk({tag, "_rdata"}, 32'(rsp_rdata), 32'(exp_rd));
    chk({tag, "_err"},   32'(rsp_err),   32'(exp_err));
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; master_busy = 1'b0; master_done = 1'b0; master_ack_error = 1'b0;
    master_data_out = 8'hEE; t_cmd_valid = 1'b0; t_rsp_ready = 1'b0;
    repeat (2) cyc();
    chk("rst_count", 32'(cmd_count), 0);
    chk("rst_start", 32'(start_txn), 0);
    chk("rst_rw", 32'(rw), 0);
    chk("rst_sub_addr", 32'(sub_addr), 0);
    chk("rst_mdi", 32'(mdi), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 0);
    chk("rst_rsp_err", 32'(rsp_err), 0);
    chk("rst_idle", 32'(idle), 1);
    chk("rst_cmd_ready", 32'(cmd_ready), 0);
    rst = 1'b0;
    cyc();
    chk("post_rst_cmd_ready", 32'(cmd_ready), 1);

    // write with busy after 3 cycles, done after ~200
    push(1'b0, 7'h01, 8'hAA);
    chk("t1_count_after_push", 32'(cmd_count), 1);
    chk("t1_start_before_pop", 32'(start_txn), 0);
    cyc();
    chk("t1_start_launch", 32'(start_txn), 1);
    chk("t1_sub_addr", 32'(sub_addr), 'h01);
    chk("t1_mdi", 32'(mdi), 'hAA);
    chk("t1_rw", 32'(rw), 0);
    chk("t1_count_after_pop", 32'(cmd_count), 0);
    cyc(); cyc();
    chk("t1_start_held", 32'(start_txn), 1);
    master_busy = 1'b1;
    cyc();
    chk("t1_start_drop_on_busy", 32'(start_txn), 0);
    repeat (195) cyc();
    finish_txn(1'b0, 8'h99);
    chk("t1_rsp_not_yet", 32'(rsp_valid), 0);
    get_rsp("t1", 8'h00, 2'b00);
    chk("t1_sub_addr_stable", 32'(sub_addr), 'h01);
    chk("t1_mdi_stable", 32'(mdi), 'hAA);
    chk("t1_idle", 32'(idle), 1);

    // read returns master data
    push(1'b1, 7'h03, 8'h00);
    cyc();
    chk("t2_rw", 32'(rw), 1);
    master_busy = 1'b1;
    cyc();
    repeat (5) cyc();
    finish_txn(1'b0, 8'h5C);
    get_rsp("t2", 8'h5C, 2'b00);

    // NACK on write (done while still in LAUNCH); following command still issues
    push(1'b0, 7'h7F, 8'h11);
    cyc();
    push(1'b0, 7'h10, 8'h22);
    finish_txn(1'b1, 8'h99);
    get_rsp("t3_nack", 8'h00, 2'b01);
    chk("t3_next_start", 32'(start_txn), 1);
    chk("t3_next_addr", 32'(sub_addr), 'h10);
    chk("t3_next_mdi", 32'(mdi), 'h22);
    finish_txn(1'b0, 8'h99);
    get_rsp("t3_next", 8'h00, 2'b00);

    // fill the FIFO, stall in RESP, then drain in order
    for (int j = 0; j < 5; j++) begin
      cmd_valid = 1'b1; cmd_rw = c_rw[j]; cmd_addr = c_ad[j]; cmd_wdata = 8'h30 + 8'(j);
      cyc();
    end
    chk("t4_count_full", 32'(cmd_count), 4);
    chk("t4_ready_full", 32'(cmd_ready), 0);
    cmd_rw = 1'b0; cmd_addr = 7'h55; cmd_wdata = 8'h55;
    cyc();
    cmd_valid = 1'b0;
    chk("t4_no_push_full", 32'(cmd_count), 4);
    chk("t4_c0_addr", 32'(sub_addr), 'h20);
    finish_txn(1'b0, 8'hA0);
    cyc();
    cyc();
    chk("t4_c1_start", 32'(start_txn), 1);
    chk("t4_c1_addr", 32'(sub_addr), 'h21);
    chk("t4_count_3", 32'(cmd_count), 3);
    finish_txn(1'b0, 8'hA1);
    for (int k = 0; k < 3; k++) begin
      if (k == 1) begin
        master_done = 1'b1; master_ack_error = 1'b1; master_data_out = 8'h77;
      end
      cyc();
      master_done = 1'b0; master_ack_error = 1'b0; master_data_out = 8'hEE;
      chk($sformatf("t4_stall_valid_%0d", k), 32'(rsp_valid), 1);
      chk($sformatf("t4_stall_rdata_%0d", k), 32'(rsp_rdata), 'hA0);
      chk($sformatf("t4_stall_err_%0d", k), 32'(rsp_err), 0);
      chk($sformatf("t4_stall_start_%0d", k), 32'(start_txn), 0);
      chk($sformatf("t4_stall_count_%0d", k), 32'(cmd_count), 3);
    end
    get_rsp("t4_c0", c_rd[0], 2'b00);
    get_rsp("t4_c1", c_rd[1], 2'b00);
    for (int j = 2; j < 5; j++) begin
      wait_start($sformatf("t4_c%0d_start", j));
      chk($sformatf("t4_c%0d_addr", j), 32'(sub_addr), 32'(c_ad[j]));
      finish_txn(1'b0, 8'hA0 + 8'(j));
      get_rsp($sformatf("t4_c%0d", j), c_rd[j], 2'b00);
    end
    chk("t4_idle_end", 32'(idle), 1);
    chk("t4_count_end", 32'(cmd_count), 0);

    // timeout instance: master never responds
    t_cmd_valid = 1'b1;
    cyc();
    t_cmd_valid = 1'b0;
    cyc();
    chk("t5_start", 32'(t_start_txn), 1);
    repeat (99) cyc();
    chk("t5_start_last", 32'(t_start_txn), 1);
    cyc();
    chk("t5_start_dropped", 32'(t_start_txn), 0);
    cyc();
    chk("t5_rsp_valid", 32'(t_rsp_valid), 1);
    chk("t5_rsp_err", 32'(t_rsp_err), 2);
    chk("t5_rsp_rdata", 32'(t_rsp_rdata), 0);
    t_rsp_ready = 1'b1;
    cyc();
    t_rsp_ready = 1'b0;
    chk("t5_idle", 32'(t_idle), 1);

    // reset mid-RUN with two queued
    push(1'b0, 7'h30, 8'h33);
    cyc();
    master_busy = 1'b1;
    cyc();
    push(1'b0, 7'h31, 8'h34);
    push(1'b0, 7'h32, 8'h35);
    chk("t6_count_pre", 32'(cmd_count), 2);
    rst = 1'b1;
    #1;
    chk("t6_start", 32'(start_txn), 0);
    chk("t6_count", 32'(cmd_count), 0);
    chk("t6_rsp_valid", 32'(rsp_valid), 0);
    chk("t6_idle", 32'(idle), 1);
    chk("t6_sub_addr", 32'(sub_addr), 0);
    cyc();
    rst = 1'b0; master_busy = 1'b0;
    cyc();
    push(1'b0, 7'h35, 8'h5A);
    wait_start("t6_new_start");
    chk("t6_new_addr", 32'(sub_addr), 'h35);
    chk("t6_new_mdi", 32'(mdi), 'h5A);
    master_busy = 1'b1;
    cyc();
    finish_txn(1'b0, 8'h99);
    get_rsp("t6_new", 8'h00, 2'b00);
    chk("t6_idle_end", 32'(idle), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
